// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for the shared UART TX arbiter.
// master = requesters plus transmitter feedback; slave = the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int OW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ-1:0]            gnt;
  logic                          tx_start;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_done;
  logic [OW-1:0]                 owner;
  logic                          busy;
  logic                          err_timeout;

  modport master (
    output req, req_data, req_lock, tx_done,
    input  gnt, tx_start, tx_data, owner, busy, err_timeout
  );

  modport slave (
    input  req, req_data, req_lock, tx_done,
    output gnt, tx_start, tx_data, owner, busy, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter, with per-requester byte locking and a tx_done timeout.
// Latency: req -> gnt 1 clk, gnt -> tx_start 1 clk; all outputs are registered.
// Backpressure: requests are level-held until gnt; one frame in flight until tx_done or timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int OW = $clog2(NUM_REQ);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, ERR} state_t;

  state_t                state;
  logic [OW-1:0]         last_owner;
  logic [OW-1:0]         owner_q;
  logic [15:0]           cnt;
  logic [NUM_REQ-1:0]    gnt_q;
  logic                  tx_start_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  busy_q;
  logic                  err_q;

  logic                  pick_vld;
  logic [OW-1:0]         pick_idx;
  logic [OW-1:0]         cand;
  logic                  relock;

  // Search starts just above the previous owner, so the previous owner is tried last.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = OW'((int'(last_owner) + i) % NUM_REQ);
      if (!pick_vld && bus.req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign relock = bus.req_lock[owner_q] && bus.req[owner_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_owner <= OW'(NUM_REQ - 1);
      owner_q    <= '0;
      cnt        <= '0;
      gnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      gnt_q      <= '0;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt_q     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
            tx_data_q <= bus.req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
            owner_q   <= pick_idx;
            busy_q    <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          tx_start_q <= 1'b1;
          cnt        <= '0;
          state      <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // tx_done is tested first so it beats a coincident timeout.
          if (bus.tx_done) begin
            if (relock) begin
              gnt_q     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
              tx_data_q <= bus.req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
              state     <= LAUNCH;
            end else begin
              last_owner <= owner_q;
              busy_q     <= 1'b0;
              state      <= IDLE;
            end
          end else if (cnt >= TO_LAST) begin
            err_q      <= 1'b1;
            last_owner <= owner_q;
            state      <= ERR;
          end else if (cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
          end
        end
        ERR: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.owner       = owner_q;
  assign bus.busy        = busy_q;
  assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single request, fairness, lock, timeout,
// tx_done/timeout collision, ignored tx_done and mid-frame reset.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus();

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst          = 1'b0;
    bus.req      = '0;
    bus.req_lock = '0;
    bus.tx_done  = 1'b0;
    bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    tick;
    tick;
    rst = 1'b1;
  endtask

  task automatic pulse_done;
    bus.tx_done = 1'b1;
    tick;
    bus.tx_done = 1'b0;
  endtask

  task automatic test_reset;
    rst          = 1'b0;
    bus.req      = 4'b1111;
    bus.req_lock = '0;
    bus.tx_done  = 1'b0;
    bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    tick;
    tick;
    tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
    tests++; if (bus.tx_start !== 1'b0) begin fails++; $display("FAIL reset_tx_start: got %b want 0", bus.tx_start); end
    tests++; if (bus.tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
    tests++; if (bus.owner !== 2'd0) begin fails++; $display("FAIL reset_owner: got %0d want 0", bus.owner); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    tests++; if (bus.err_timeout !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", bus.err_timeout); end
    bus.req = 4'b0000;
    rst     = 1'b1;
  endtask

  task automatic test_single;
    do_reset;
    bus.req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    bus.req      = 4'b0100;
    tick;
    tests++; if (bus.gnt !== 4'b0100) begin fails++; $display("FAIL single_gnt: got %b want 0100", bus.gnt); end
    tests++; if (bus.owner !== 2'd2) begin fails++; $display("FAIL single_owner: got %0d want 2", bus.owner); end
    tests++; if (bus.tx_start !== 1'b0) begin fails++; $display("FAIL single_early_start: got %b want 0", bus.tx_start); end
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL single_busy_launch: got %b want 1", bus.busy); end
    bus.req = 4'b0000;
    tick;
    tests++; if (bus.tx_start !== 1'b1) begin fails++; $display("FAIL single_tx_start: got %b want 1", bus.tx_start); end
    tests++; if (bus.tx_data !== 8'hA5) begin fails++; $display("FAIL single_tx_data: got %h want a5", bus.tx_data); end
    tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL single_gnt_pulse: got %b want 0000", bus.gnt); end
    tick;
    tests++; if (bus.tx_start !== 1'b0) begin fails++; $display("FAIL single_start_pulse: got %b want 0", bus.tx_start); end
    tick;
    bus.tx_done = 1'b1;
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL single_busy_wait: got %b want 1", bus.busy); end
    tick;
    bus.tx_done = 1'b0;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL single_busy_after: got %b want 0", bus.busy); end
    tests++; if (bus.tx_data !== 8'hA5) begin fails++; $display("FAIL single_data_hold: got %h want a5", bus.tx_data); end
  endtask

  task automatic test_fairness;
    logic [3:0] eg;
    logic [7:0] dtab [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int n;
    do_reset;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      eg = 4'b0001 << (k % 4);
      n  = 0;
      while (bus.gnt === 4'b0000 && n < 20) begin
        tick;
        n++;
      end
      tests++; if (bus.gnt !== eg) begin fails++; $display("FAIL fair_gnt%0d: got %b want %b", k, bus.gnt, eg); end
      tick;
      tests++; if (bus.tx_data !== dtab[k % 4]) begin fails++; $display("FAIL fair_data%0d: got %h want %h", k, bus.tx_data, dtab[k % 4]); end
      repeat (9) tick;
      pulse_done;
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_lock;
    do_reset;
    bus.req_data = {8'h44, 8'h33, 8'hB1, 8'hA0};
    bus.req      = 4'b0011;
    bus.req_lock = 4'b0001;
    tick;
    tests++; if (bus.gnt !== 4'b0001) begin fails++; $display("FAIL lock_gnt0: got %b want 0001", bus.gnt); end
    bus.req_data[7:0] = 8'hA1;
    tick;
    tests++; if (bus.tx_data !== 8'hA0) begin fails++; $display("FAIL lock_data0: got %h want a0", bus.tx_data); end
    repeat (3) tick;
    pulse_done;
    tests++; if (bus.gnt !== 4'b0001) begin fails++; $display("FAIL lock_gnt1: got %b want 0001", bus.gnt); end
    bus.req_data[7:0] = 8'hA2;
    tick;
    tests++; if (bus.tx_data !== 8'hA1) begin fails++; $display("FAIL lock_data1: got %h want a1", bus.tx_data); end
    repeat (3) tick;
    pulse_done;
    tests++; if (bus.gnt !== 4'b0001) begin fails++; $display("FAIL lock_gnt2: got %b want 0001", bus.gnt); end
    tick;
    tests++; if (bus.tx_data !== 8'hA2) begin fails++; $display("FAIL lock_data2: got %h want a2", bus.tx_data); end
    bus.req_lock = 4'b0000;
    bus.req      = 4'b0010;
    repeat (3) tick;
    pulse_done;
    tests++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin fails++; $display("FAIL lock_release: got gnt=%b busy=%b want 0000/0", bus.gnt, bus.busy); end
    tick;
    tests++; if (bus.gnt !== 4'b0010) begin fails++; $display("FAIL lock_next: got %b want 0010", bus.gnt); end
    tick;
    tests++; if (bus.tx_data !== 8'hB1) begin fails++; $display("FAIL lock_next_data: got %h want b1", bus.tx_data); end
    bus.req = 4'b0000;
  endtask

  task automatic test_timeout;
    int n;
    do_reset;
    bus.req = 4'b0100;
    tick;
    tests++; if (bus.gnt !== 4'b0100) begin fails++; $display("FAIL to_gnt: got %b want 0100", bus.gnt); end
    bus.req = 4'b0000;
    tick;
    n = 0;
    while (bus.err_timeout !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    tests++; if (n !== 16) begin fails++; $display("FAIL to_delay: got %0d cycles want 16", n); end
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL to_busy_err: got %b want 1", bus.busy); end
    tick;
    tests++; if (bus.err_timeout !== 1'b0) begin fails++; $display("FAIL to_err_pulse: got %b want 0", bus.err_timeout); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL to_idle: got %b want 0", bus.busy); end
    bus.req = 4'b1111;
    tick;
    tests++; if (bus.gnt !== 4'b1000) begin fails++; $display("FAIL to_next_gnt: got %b want 1000", bus.gnt); end
    bus.req = 4'b0000;
  endtask

  task automatic test_same_cycle;
    do_reset;
    bus.req = 4'b0001;
    tick;
    bus.req = 4'b0000;
    tick;
    repeat (15) tick;
    bus.tx_done = 1'b1;
    tick;
    bus.tx_done = 1'b0;
    tests++; if (bus.err_timeout !== 1'b0) begin fails++; $display("FAIL same_err: got %b want 0", bus.err_timeout); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL same_idle: got %b want 0", bus.busy); end
    tick;
    tests++; if (bus.err_timeout !== 1'b0) begin fails++; $display("FAIL same_err_late: got %b want 0", bus.err_timeout); end
    bus.req = 4'b1111;
    tick;
    tests++; if (bus.gnt !== 4'b0010) begin fails++; $display("FAIL same_next_gnt: got %b want 0010", bus.gnt); end
    bus.req = 4'b0000;
  endtask

  task automatic test_ignore_done;
    do_reset;
    pulse_done;
    tests++; if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin fails++; $display("FAIL ign_idle: got busy=%b gnt=%b want 0/0000", bus.busy, bus.gnt); end
    bus.req = 4'b0001;
    tick;
    bus.req = 4'b0000;
    pulse_done;
    tests++; if (bus.tx_start !== 1'b1) begin fails++; $display("FAIL ign_launch_start: got %b want 1", bus.tx_start); end
    tick;
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL ign_launch_busy: got %b want 1", bus.busy); end
    pulse_done;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL ign_finish: got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    bus.req = 4'b0001;
    tick;
    bus.req = 4'b0000;
    repeat (4) tick;
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL mid_busy_pre: got %b want 1", bus.busy); end
    #2;
    rst = 1'b0;
    #1;
    tests++; if (bus.tx_data !== 8'h00 || bus.owner !== 2'd0) begin fails++; $display("FAIL mid_data_owner: got %h/%0d want 00/0", bus.tx_data, bus.owner); end
    tests++; if (bus.busy !== 1'b0 || bus.err_timeout !== 1'b0) begin fails++; $display("FAIL mid_busy_err: got %b/%b want 0/0", bus.busy, bus.err_timeout); end
    bus.req = 4'b1000;
    tick;
    tests++; if (bus.gnt !== 4'b0000 || bus.tx_start !== 1'b0) begin fails++; $display("FAIL mid_in_reset: got gnt=%b start=%b want 0000/0", bus.gnt, bus.tx_start); end
    rst = 1'b1;
    tick;
    tests++; if (bus.gnt !== 4'b1000) begin fails++; $display("FAIL mid_after_gnt: got %b want 1000", bus.gnt); end
    bus.req = 4'b0000;
  endtask

  initial begin
    test_reset;
    test_single;
    test_fairness;
    test_lock;
    test_timeout;
    test_same_cycle;
    test_ignore_done;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
